temp_sample_conv: RTL and testbench
===================================

# temp_sample_conv

Upstream stage of the LED panel temperature display. Accepts raw signed temperature words in DS18B20 format (1/16 °C per LSB) from the sensor interface and block-averages 2^AVG_LOG2 samples. Converts the average to rounded integer Celsius and Fahrenheit, then presents stable 8-bit `c_val` / `f_val` registers that the panel display's pixel generators read directly. All logic runs on the system clock `clk`, not the divided matrix clock.

## Interface

Parameters:
- `AVG_LOG2`, default 3: log2 of the number of samples per block average (8 samples). Legal values 0..4.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `raw_valid`  in  1  one-cycle strobe; `raw_temp` is valid this cycle.
- `raw_temp`  in  16  signed two's complement temperature, 1/16 °C per LSB.
- `c_val`  out  8  unsigned Celsius, clamped to 0..99.
- `f_val`  out  8  unsigned Fahrenheit, range 32..210.
- `upd`  out  1  one-cycle pulse, high in the cycle after `c_val`/`f_val` change.
- `busy`  out  1  conversion in progress; samples are ignored while high.
- `overrun`  out  1  sticky flag: a `raw_valid` arrived while `busy`. Cleared only by `rst`.

## Operation

- FSM states are ACC, AVG, MUL, DIV, COMMIT. Reset state is ACC.
- **ACC**
  - On `raw_valid`, sign-extend `raw_temp` and add it to `acc`, which is signed, 16+AVG_LOG2 bits. Increment `n`, which is AVG_LOG2 bits and wraps.
  - When the accepted sample is number 2^AVG_LOG2 (n wraps to 0), go to AVG.
- **AVG**
  - `avg = acc >>> AVG_LOG2` (arithmetic shift).
  - `c_raw = (avg + 8) >>> 4`, which rounds half up in 1/16 units.
  - Clamp: if `c_raw < 0` then C = 0; if `c_raw > 99` then C = 99; otherwise C = `c_raw[7:0]`. Latch C into `c_tmp`.
  - Clear `acc`, then go to MUL.
- **MUL**
  - `num = 9*c_tmp + 2` (10 bits, maximum 893), computed by shift-add `(c_tmp<<3)+c_tmp+2`.
  - Clear the quotient, set the step counter to 0, then go to DIV.
- **DIV**
  - 10-step restoring division of `num` by 5, one quotient bit per cycle, MSB first. The remainder register is 4 bits wide.
  - After step 9, go to COMMIT. Quotient `q = floor((9C+2)/5)`, which rounds 9C/5 half up.
- **COMMIT**
  - Register `c_val <= c_tmp` and `f_val <= q + 32` on the same edge (atomic update). Assert `upd` for exactly that following cycle, then go to ACC.
- `busy` is high in every state except ACC.
- `raw_valid` while `busy` is dropped: `acc` and `n` are unchanged and `overrun` is set.
- Samples accepted after COMMIT start a fresh block; there is no sliding window.
- `rst` in any state clears the following regardless of `raw_valid` in the same cycle:
  - FSM returns to ACC.
  - `acc`, `n`, `c_tmp`, quotient and remainder go to 0.
  - Outputs: `c_val = 0`, `f_val = 32`, `upd = 0`, `busy = 0`, `overrun = 0`.
  - A block that was partially accumulated is discarded.

## Timing

- Edge E0 accepts the final sample of a block. After E0, `busy = 1`.
  - E1 executes AVG.
  - E2 executes MUL.
  - E3..E12 execute the 10 DIV steps.
  - E13 executes COMMIT: `c_val`, `f_val` and `upd` update, and `busy` returns to 0.
- Fixed latency: 13 clocks from the accepting edge to the new output values. `upd` is high for 1 cycle.
- A `raw_valid` in the cycle just before E13 is still dropped. The first sample of the next block can be accepted on E14.
- Minimum block period: 2^AVG_LOG2 + 13 cycles when samples arrive back-to-back and are timed to avoid drops.
- `c_val`/`f_val` are constant between `upd` pulses, so the panel may sample them asynchronously with respect to conversion.

## Test plan

- **Reset:** apply `rst` mid-accumulation, after 5 samples of 0x0190. Expect `c_val = 0`, `f_val = 32`, `busy = 0`, `overrun = 0`. Then 8 samples of 0x0190 (25.0 °C) give `c_val = 25`, `f_val = 77`.
- **Rounding:** 8 × 0x0250 (37.0 °C) gives `c_val = 37`, `f_val = 99`, with `upd` exactly 13 cycles after the 8th strobe. 8 × 0x0178 (23.5 °C) gives `c_val = 24`, `f_val = 75`.
- **Clamping:** 8 × 0xFF5E (−10.125 °C) gives `c_val = 0`, `f_val = 32`. 8 × 0x07D0 (125 °C) gives `c_val = 99`, `f_val = 210`.
- **Averaging:** 4 × 0x0140 plus 4 × 0x01E0 (20 °C and 30 °C) gives `c_val = 25`, `f_val = 77`. Any single block containing mixed signs is computed with a signed sum.
- **Overrun:** assert `raw_valid` every cycle for 30 cycles with 0x0190.
  - `overrun` goes to 1 on the 9th strobe.
  - Exactly 8 samples are accepted before the first `upd`.
  - Accepting resumes on E14.
  - `overrun` stays 1 until `rst`.
- **Sweep:** for every C in 0..99 (raw = C×16), check `f_val == floor((9C+2)/5) + 32` and confirm `c_val`/`f_val` never change outside an `upd` cycle.

Source files
------------

// File: rtl/temp_sample_conv.sv
`default_nettype none
// ============================================================================
// Module   : temp_sample_conv
// Brief    : Block-averages DS18B20 temperature words and converts the average
//            to clamped integer Celsius and Fahrenheit display registers.
// Revision : 1.0 - initial release
// ============================================================================
module temp_sample_conv #(
    parameter int AVG_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        raw_valid,
    input  logic [15:0] raw_temp,
    output logic [7:0]  c_val,
    output logic [7:0]  f_val,
    output logic        upd,
    output logic        busy,
    output logic        overrun
);

    localparam int              ACC_W      = 16 + AVG_LOG2;
    localparam int              N_W        = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [N_W-1:0]  C_N_LAST   = N_W'((1 << AVG_LOG2) - 1);
    localparam logic [3:0]      C_DIV_LAST = 4'd9;
    localparam logic [7:0]      C_C_MAX    = 8'd99;
    localparam logic [7:0]      C_F_OFFSET = 8'd32;

    typedef enum logic [2:0] {
        S_ACC    = 3'd0,
        S_AVG    = 3'd1,
        S_MUL    = 3'd2,
        S_DIV    = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic signed [ACC_W-1:0]  r_acc;
    logic [N_W-1:0]           r_n;
    logic [7:0]               r_c_tmp;
    logic [9:0]               r_num;
    logic [7:0]               r_q;
    logic [3:0]               r_rem;
    logic [3:0]               r_step;
    logic [7:0]               r_c_val;
    logic [7:0]               r_f_val;
    logic                     r_upd;
    logic                     r_overrun;

    logic signed [ACC_W-1:0]  w_sample;
    logic signed [ACC_W:0]    w_acc_ext;
    logic signed [ACC_W:0]    w_avg;
    logic signed [ACC_W:0]    w_rnd;
    logic signed [ACC_W:0]    w_c_raw;
    logic                     w_neg;
    logic                     w_big;
    logic [7:0]               w_c_clamp;
    logic [9:0]               w_num;
    logic [4:0]               w_shift;
    logic                     w_ge;
    logic [3:0]               w_rem_next;
    logic                     w_last;

    assign w_sample  = ACC_W'($signed(raw_temp));
    assign w_last    = (r_n == C_N_LAST);

    // One extra bit keeps the +8 rounding term from overflowing at full scale.
    assign w_acc_ext = {r_acc[ACC_W-1], r_acc};
    assign w_avg     = w_acc_ext >>> AVG_LOG2;
    assign w_rnd     = w_avg + (ACC_W+1)'(8);
    assign w_c_raw   = w_rnd >>> 4;
    assign w_neg     = w_c_raw[ACC_W];
    assign w_big     = !w_neg && (w_c_raw[ACC_W-1:0] > ACC_W'(99));
    assign w_c_clamp = w_neg ? 8'd0 : (w_big ? C_C_MAX : w_c_raw[7:0]);

    assign w_num      = (10'(r_c_tmp) << 3) + 10'(r_c_tmp) + 10'd2;
    assign w_shift    = {r_rem, r_num[9]};
    assign w_ge       = (w_shift >= 5'd5);
    assign w_rem_next = w_ge ? 4'(w_shift - 5'd5) : w_shift[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ACC:    if (raw_valid && w_last) w_next = S_AVG;
            S_AVG:    w_next = S_MUL;
            S_MUL:    w_next = S_DIV;
            S_DIV:    if (r_step == C_DIV_LAST) w_next = S_COMMIT;
            S_COMMIT: w_next = S_ACC;
            default:  w_next = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_n       <= '0;
            r_c_tmp   <= '0;
            r_num     <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_step    <= '0;
            r_c_val   <= '0;
            r_f_val   <= C_F_OFFSET;
            r_upd     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (raw_valid && busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_ACC: begin
                    if (raw_valid) begin
                        r_acc <= r_acc + w_sample;
                        r_n   <= w_last ? '0 : r_n + N_W'(1);
                    end
                end
                S_AVG: begin
                    r_c_tmp <= w_c_clamp;
                    r_acc   <= '0;
                end
                S_MUL: begin
                    r_num  <= w_num;
                    r_q    <= '0;
                    r_rem  <= '0;
                    r_step <= '0;
                end
                S_DIV: begin
                    // Quotient never exceeds 178, so the top two bits are always 0.
                    r_num  <= {r_num[8:0], 1'b0};
                    r_rem  <= w_rem_next;
                    r_q    <= {r_q[6:0], w_ge};
                    r_step <= r_step + 4'd1;
                end
                S_COMMIT: begin
                    r_c_val <= r_c_tmp;
                    r_f_val <= r_q + C_F_OFFSET;
                    r_upd   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != S_ACC);
    assign c_val   = r_c_val;
    assign f_val   = r_f_val;
    assign upd     = r_upd;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_temp_sample_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_temp_sample_conv
// Brief    : Directed self-checking bench for temp_sample_conv.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temp_sample_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        raw_valid = 1'b0;
    logic [15:0] raw_temp = 16'h0000;
    logic [7:0]  c_val;
    logic [7:0]  f_val;
    logic        upd;
    logic        busy;
    logic        overrun;

    int   n_vec = 0;
    int   n_err = 0;
    int   stable_err = 0;
    int   lat;
    int   acc_cnt;
    int   upd_k;
    int   resume_k;
    logic bsy;
    logic [7:0] prev_c;
    logic [7:0] prev_f;

    always #5 clk = ~clk;

    temp_sample_conv #(.AVG_LOG2(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_valid (raw_valid),
        .raw_temp  (raw_temp),
        .c_val     (c_val),
        .f_val     (f_val),
        .upd       (upd),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs may only move on an edge that also raises upd (reset excepted).
    always @(posedge clk) begin
        #2;
        if (!rst && ((c_val !== prev_c) || (f_val !== prev_f)) && !upd)
            stable_err++;
        prev_c = c_val;
        prev_f = f_val;
    end

    task automatic apply_reset();
        @(negedge clk);
        raw_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Four samples of a then four of b, back to back; lat = edges from E0 to upd.
    task automatic run_block(input logic [15:0] a, input logic [15:0] b, output int l);
        l = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            raw_valid = 1'b1;
            raw_temp  = (i < 4) ? a : b;
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            raw_valid = 1'b0;
            if (upd) begin
                l = k;
                break;
            end
        end
        if (l < 0) begin
            check("upd_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            check("upd_width", upd, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_c",    c_val,   0);
        check("rst_f",    f_val,   32);
        check("rst_busy", busy,    0);
        check("rst_ovr",  overrun, 0);
        check("rst_upd",  upd,     0);
        rst = 1'b0;

        // Partial block, then reset mid-accumulation
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            raw_valid = 1'b1;
            raw_temp  = 16'h0190;
        end
        apply_reset();
        check("mid_rst_c",    c_val,   0);
        check("mid_rst_f",    f_val,   32);
        check("mid_rst_busy", busy,    0);
        check("mid_rst_ovr",  overrun, 0);

        run_block(16'h0190, 16'h0190, lat);
        check("b25_c", c_val, 25);
        check("b25_f", f_val, 77);
        check("b25_lat", lat, 13);

        run_block(16'h0250, 16'h0250, lat);
        check("b37_c", c_val, 37);
        check("b37_f", f_val, 99);
        check("b37_lat", lat, 13);

        run_block(16'h0178, 16'h0178, lat);
        check("half_c", c_val, 24);
        check("half_f", f_val, 75);

        run_block(16'hFF5E, 16'hFF5E, lat);
        check("neg_c", c_val, 0);
        check("neg_f", f_val, 32);

        run_block(16'h07D0, 16'h07D0, lat);
        check("hot_c", c_val, 99);
        check("hot_f", f_val, 210);

        run_block(16'h0140, 16'h01E0, lat);
        check("avg_c", c_val, 25);
        check("avg_f", f_val, 77);

        // -16 C and +48 C averaged: signed sum gives 16 C
        run_block(16'hFF00, 16'h0300, lat);
        check("mix_c", c_val, 16);
        check("mix_f", f_val, 61);

        // Continuous strobes: 8 accepted, then 13 busy cycles, resume on E14
        apply_reset();
        @(negedge clk);
        raw_valid = 1'b1;
        raw_temp  = 16'h0190;
        acc_cnt  = 0;
        upd_k    = 0;
        resume_k = 0;
        for (int k = 1; k <= 30; k++) begin
            bsy = busy;
            @(posedge clk);
            #1;
            if (!bsy && upd_k == 0) acc_cnt++;
            if (!bsy && upd_k != 0 && resume_k == 0) resume_k = k;
            if (k == 8) check("ovr_before", overrun, 0);
            if (k == 9) check("ovr_set", overrun, 1);
            if (upd && upd_k == 0) upd_k = k;
            @(negedge clk);
        end
        raw_valid = 1'b0;
        check("ovr_accepted", acc_cnt, 8);
        check("ovr_upd_edge", upd_k, 21);
        check("ovr_resume", resume_k, 22);
        repeat (20) @(negedge clk);
        check("ovr_sticky", overrun, 1);
        check("ovr_c", c_val, 25);
        apply_reset();
        check("ovr_cleared", overrun, 0);

        for (int c = 0; c < 100; c++) begin
            run_block(16'(c * 16), 16'(c * 16), lat);
            check("sweep_c", c_val, c);
            check("sweep_f", f_val, (9 * c + 2) / 5 + 32);
        end

        repeat (2) @(negedge clk);
        check("stable_outputs", stable_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
